// File: rtl/uart_receiver_pkg.sv
// Shared receiver definitions: FSM state encoding, oversampling constants
// and the baud_select divisor table used by the transmitter as well.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int MID_TICK_DEF   = 7;
  localparam int BAUD_CNT_W     = 14;

  // System clocks per sample_ENABLE tick (50 MHz clock, 16x oversampling).
  function automatic logic [BAUD_CNT_W-1:0] baud_divisor(input logic [2:0] sel);
    logic [BAUD_CNT_W-1:0] div;
    case (sel)
      3'b000:  div = 14'd10417;
      3'b001:  div = 14'd2604;
      3'b010:  div = 14'd651;
      3'b011:  div = 14'd326;
      3'b100:  div = 14'd163;
      3'b101:  div = 14'd81;
      3'b110:  div = 14'd54;
      3'b111:  div = 14'd27;
      default: div = 14'd27;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_receiver_baud_controller.sv
// Baud-rate tick generator: one-clock sample_ENABLE pulse every
// baud_divisor(baud_select) clocks; active-high asynchronous reset.
module baud_controller
  import uart_receiver_pkg::*;
(
  input  logic       reset,
  input  logic       clk,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);

  logic [BAUD_CNT_W-1:0] div_s;
  logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  en_q, en_d;

  // ">=" rather than "==" so a rate change never strands the counter above the new limit.
  always_comb begin
    div_s = baud_divisor(baud_select);
    if (cnt_q >= (div_s - 14'd1)) begin
      cnt_d = 14'd0;
      en_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 14'd1;
      en_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 14'd0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign sample_ENABLE = en_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 1 start, 8 data LSB-first, even parity, 1 stop; 16x
// oversampled with mid-bit sampling, reporting bytes and parity/framing errors.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int MID_TICK   = MID_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_IDX   = 4'(MID_TICK);

  logic       Rx_sample_ENABLE;
  logic       sync1_q, sync_q, prev_q;
  rx_state_e  state_q;
  logic [3:0] tick_q;
  logic [3:0] tick_nxt_s;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       xor_q, perr_q;
  logic [7:0] rx_data_q;
  logic       valid_q, perror_q, ferror_q;

  baud_controller baud_controller_rx_instance (
    .reset         (~reset),
    .clk           (clk),
    .baud_select   (baud_select),
    .sample_ENABLE (Rx_sample_ENABLE)
  );

  // prev_q follows the line per tick, not per clock, so an edge between ticks is still seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= RxD;
      sync_q  <= sync1_q;
      if (Rx_sample_ENABLE) begin
        prev_q <= sync_q;
      end else begin
        prev_q <= prev_q;
      end
    end
  end

  always_comb begin
    tick_nxt_s = (tick_q == LAST_TICK) ? 4'd0 : (tick_q + 4'd1);
  end

  // The start-edge tick is tick 0, so the start sample lands MID_TICK ticks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      xor_q     <= 1'b0;
      perr_q    <= 1'b0;
      rx_data_q <= 8'h00;
      valid_q   <= 1'b0;
      perror_q  <= 1'b0;
      ferror_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!Rx_EN) begin
        state_q <= ST_IDLE;
        tick_q  <= 4'd0;
        bit_q   <= 3'd0;
        shift_q <= 8'h00;
        xor_q   <= 1'b0;
        perr_q  <= 1'b0;
      end else if (Rx_sample_ENABLE) begin
        case (state_q)
          ST_IDLE: begin
            if (prev_q && !sync_q) begin
              state_q  <= ST_START;
              tick_q   <= 4'd0;
              perror_q <= 1'b0;
              ferror_q <= 1'b0;
            end
          end
          ST_START: begin
            if (tick_nxt_s == MID_IDX) begin
              tick_q <= 4'd0;
              bit_q  <= 3'd0;
              xor_q  <= 1'b0;
              state_q <= sync_q ? ST_IDLE : ST_DATA;
            end else begin
              tick_q <= tick_nxt_s;
            end
          end
          ST_DATA: begin
            tick_q <= tick_nxt_s;
            if (tick_q == LAST_TICK) begin
              shift_q[bit_q] <= sync_q;
              xor_q          <= xor_q ^ sync_q;
              if (bit_q == 3'd7) begin
                state_q <= ST_PARITY;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end
          end
          ST_PARITY: begin
            tick_q <= tick_nxt_s;
            if (tick_q == LAST_TICK) begin
              perr_q  <= sync_q ^ xor_q;
              state_q <= ST_STOP;
            end
          end
          ST_STOP: begin
            tick_q <= tick_nxt_s;
            if (tick_q == LAST_TICK) begin
              if (sync_q && !perr_q) begin
                rx_data_q <= shift_q;
                valid_q   <= 1'b1;
              end
              if (!sync_q) begin
                ferror_q <= 1'b1;
              end
              if (perr_q) begin
                perror_q <= 1'b1;
              end
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
          end
        endcase
      end
    end
  end

  assign Rx_DATA   = rx_data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perror_q;
  assign Rx_FERROR = ferror_q;

endmodule
